// File: rtl/rtc_lector_fecha.sv
// rtc_lector_fecha: reads the day/month/year BCD registers of an external RTC over
// its multiplexed AD bus and returns them in binary. Optional checking: RTC_LECTOR_CHECK_EN.
module rtc_lector_fecha #(
  parameter int unsigned T_PULSE   = 4,
  parameter int unsigned T_GAP     = 2,
  parameter logic [7:0]  ADDR_DIA  = 8'h24,
  parameter logic [7:0]  ADDR_MES  = 8'h25,
  parameter logic [7:0]  ADDR_ANIO = 8'h26
) (
  input  logic       clkR,
  input  logic       resetR,
  input  logic       startR,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a_d,
  output logic [4:0] diaR,
  output logic [3:0] mesR,
  output logic [6:0] anioR,
  output logic       busyR,
  output logic       doneR,
  output logic       errR
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR_SETUP = 3'd1;
  localparam logic [2:0] S_ADDR_WR    = 3'd2;
  localparam logic [2:0] S_DATA_SETUP = 3'd3;
  localparam logic [2:0] S_DATA_RD    = 3'd4;
  localparam logic [2:0] S_GAP        = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam logic [7:0] PULSE_LAST = 8'(T_PULSE - 32'd1);
  localparam logic [7:0] GAP_LAST   = 8'(T_GAP - 32'd1);

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  logic [2:0] state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [1:0] idx_r, idx_s;
  logic       cap_s;
  logic       err_s;
  logic [7:0] raw_dia_r, raw_mes_r, raw_anio_r;
  logic [7:0] addr_s;

  logic [7:0] ad_out_r;
  logic       ad_oe_r, cs_n_r, wr_n_r, rd_n_r, a_d_r;
  logic [4:0] dia_r;
  logic [3:0] mes_r;
  logic [6:0] anio_r;
  logic       busy_r, done_r, err_r;

  // Sequencer next-state: three accesses, each address write then data read then gap.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    cap_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (startR) begin
          state_s = S_ADDR_SETUP;
          idx_s   = 2'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADDR_SETUP: begin
        state_s = S_ADDR_WR;
        cnt_s   = 8'd0;
      end
      S_ADDR_WR: begin
        if (cnt_r == PULSE_LAST) begin
          state_s = S_DATA_SETUP;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_DATA_SETUP: begin
        state_s = S_DATA_RD;
        cnt_s   = 8'd0;
      end
      S_DATA_RD: begin
        if (cnt_r == PULSE_LAST) begin
          cap_s = 1'b1;
          cnt_s = 8'd0;
          // A zero-length gap chains straight into the next access.
          if (T_GAP != 32'd0) begin
            state_s = S_GAP;
          end else if (idx_r < 2'd2) begin
            state_s = S_ADDR_SETUP;
            idx_s   = idx_r + 2'd1;
          end else begin
            state_s = S_DONE;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_r != GAP_LAST) begin
          cnt_s = cnt_r + 8'd1;
        end else if (idx_r < 2'd2) begin
          state_s = S_ADDR_SETUP;
          idx_s   = idx_r + 2'd1;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Address of the register currently being fetched.
  always_comb begin
    case (idx_r)
      2'd0:    addr_s = ADDR_DIA;
      2'd1:    addr_s = ADDR_MES;
      default: addr_s = ADDR_ANIO;
    endcase
  end

`ifdef RTC_LECTOR_CHECK_EN
  // Validity of the three captured bytes as a calendar date.
  always_comb begin
    err_s = 1'b0;
    if (!bcd_ok(raw_dia_r) || !bcd_ok(raw_mes_r) || !bcd_ok(raw_anio_r)) begin
      err_s = 1'b1;
    end else if ((bcd2bin(raw_dia_r) == 7'd0) || (bcd2bin(raw_dia_r) > 7'd31)) begin
      err_s = 1'b1;
    end else if ((bcd2bin(raw_mes_r) == 7'd0) || (bcd2bin(raw_mes_r) > 7'd12)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end
`else
  assign err_s = 1'b0;
`endif

  // Sequencer state, counters and raw byte capture.
  always_ff @(posedge clkR or negedge resetR) begin
    if (!resetR) begin
      state_r    <= S_IDLE;
      cnt_r      <= 8'd0;
      idx_r      <= 2'd0;
      raw_dia_r  <= 8'h00;
      raw_mes_r  <= 8'h00;
      raw_anio_r <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      if (cap_s) begin
        case (idx_r)
          2'd0:    raw_dia_r  <= ad_in;
          2'd1:    raw_mes_r  <= ad_in;
          default: raw_anio_r <= ad_in;
        endcase
      end
    end
  end

  // Registered bus and status outputs decoded from the current state.
  always_ff @(posedge clkR or negedge resetR) begin
    if (!resetR) begin
      ad_out_r <= 8'h00;
      ad_oe_r  <= 1'b0;
      cs_n_r   <= 1'b1;
      wr_n_r   <= 1'b1;
      rd_n_r   <= 1'b1;
      a_d_r    <= 1'b0;
      dia_r    <= 5'd1;
      mes_r    <= 4'd1;
      anio_r   <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      ad_oe_r  <= (state_r == S_ADDR_SETUP) || (state_r == S_ADDR_WR);
      ad_out_r <= ((state_r == S_ADDR_SETUP) || (state_r == S_ADDR_WR)) ? addr_s : 8'h00;
      cs_n_r   <= !((state_r == S_ADDR_SETUP) || (state_r == S_ADDR_WR) ||
                    (state_r == S_DATA_SETUP) || (state_r == S_DATA_RD));
      wr_n_r   <= (state_r != S_ADDR_WR);
      rd_n_r   <= (state_r != S_DATA_RD);
      a_d_r    <= (state_r == S_DATA_SETUP) || (state_r == S_DATA_RD);
      busy_r   <= (state_r != S_IDLE);
      done_r   <= (state_r == S_DONE);
      err_r    <= (state_r == S_DONE) && err_s;
      if ((state_r == S_DONE) && !err_s) begin
        dia_r  <= 5'(bcd2bin(raw_dia_r));
        mes_r  <= 4'(bcd2bin(raw_mes_r));
        anio_r <= bcd2bin(raw_anio_r);
      end
    end
  end

  assign ad_out = ad_out_r;
  assign ad_oe  = ad_oe_r;
  assign cs_n   = cs_n_r;
  assign wr_n   = wr_n_r;
  assign rd_n   = rd_n_r;
  assign a_d    = a_d_r;
  assign diaR   = dia_r;
  assign mesR   = mes_r;
  assign anioR  = anio_r;
  assign busyR  = busy_r;
  assign doneR  = done_r;
  assign errR   = err_r;

endmodule

// File: tb/tb_rtc_lector_fecha.sv
// Bench for rtc_lector_fecha: RTC bus model, vector table, corner sequences and
// randomized dates against a date-conversion reference model.
module tb_rtc_lector_fecha;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetR, startR, start2;
  logic [7:0] ad_in, ad_out, ad_in2, ad_out2;
  logic       ad_oe, cs_n, wr_n, rd_n, a_d, busyR, doneR, errR;
  logic       ad_oe2, cs_n2, wr_n2, rd_n2, a_d2, busy2, done2, err2;
  logic [4:0] diaR, dia2;
  logic [3:0] mesR, mes2;
  logic [6:0] anioR, anio2;

  logic [7:0] rtc_d = 8'h00, rtc_m = 8'h00, rtc_y = 8'h00;
  logic [7:0] rtc_addr = 8'h00, rtc_addr2 = 8'h00;

  int checks = 0, errors = 0;
  int done_cnt = 0, overlap_cnt = 0;
  logic wr_prev = 1'b1;
  logic [7:0] addr_q[$];

  rtc_lector_fecha u_dut (
    .clkR(clk), .resetR(resetR), .startR(startR), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a_d(a_d),
    .diaR(diaR), .mesR(mesR), .anioR(anioR), .busyR(busyR), .doneR(doneR), .errR(errR)
  );

  rtc_lector_fecha #(.T_PULSE(2), .T_GAP(0)) u_fast (
    .clkR(clk), .resetR(resetR), .startR(start2), .ad_in(ad_in2), .ad_out(ad_out2),
    .ad_oe(ad_oe2), .cs_n(cs_n2), .wr_n(wr_n2), .rd_n(rd_n2), .a_d(a_d2),
    .diaR(dia2), .mesR(mes2), .anioR(anio2), .busyR(busy2), .doneR(done2), .errR(err2)
  );

  function automatic logic [7:0] rtc_read(input logic [7:0] a, input logic [7:0] d,
                                          input logic [7:0] m, input logic [7:0] y);
    case (a)
      8'h24:   return d;
      8'h25:   return m;
      8'h26:   return y;
      default: return 8'hEE;
    endcase
  endfunction

  // RTC chip model: latches the address phase, answers reads while rd_n is low.
  always @(posedge clk) begin
    if (!cs_n && !wr_n && !a_d) rtc_addr <= ad_out;
    if (!cs_n2 && !wr_n2 && !a_d2) rtc_addr2 <= ad_out2;
  end
  assign ad_in  = (!cs_n && !rd_n) ? rtc_read(rtc_addr, rtc_d, rtc_m, rtc_y) : 8'h00;
  assign ad_in2 = (!cs_n2 && !rd_n2) ? rtc_read(rtc_addr2, rtc_d, rtc_m, rtc_y) : 8'h00;

  // Bus monitors: address trace, done pulses, driver overlap.
  always @(negedge clk) begin
    wr_prev <= wr_n;
    if (!cs_n && !wr_n && !a_d && wr_prev) addr_q.push_back(ad_out);
    if (doneR) done_cnt <= done_cnt + 1;
    if ((ad_oe && !rd_n) || (ad_oe2 && !rd_n2)) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bcd_val(input logic [7:0] b);
    return ((int'(b[7:4]) * 10) + int'(b[3:0])) % 128;
  endfunction

  function automatic bit nib_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic run_seq(input string tag, input logic [7:0] d, input logic [7:0] m,
                         input logic [7:0] y, input int ed, input int em, input int ey,
                         input int ee);
    int n;
    int tr;
    rtc_d = d; rtc_m = m; rtc_y = y;
    addr_q.delete();
    startR = 1'b1;
    @(posedge clk); #1;
    startR = 1'b0;
    n = 0;
    while (doneR !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 37);
    chk({tag, "_dia"}, int'(diaR), ed);
    chk({tag, "_mes"}, int'(mesR), em);
    chk({tag, "_anio"}, int'(anioR), ey);
    chk({tag, "_err"}, int'(errR), ee);
    chk({tag, "_busy_at_done"}, int'(busyR), 1);
    tr = 0;
    foreach (addr_q[i]) tr = (tr << 8) | int'(addr_q[i]);
    chk({tag, "_addr_trace"}, tr, 32'h00242526);
    @(posedge clk); #1;
    chk({tag, "_done_single"}, int'(doneR), 0);
    chk({tag, "_busy_fall"}, int'(busyR), 0);
  endtask

  typedef struct {
    logic [7:0] d, m, y;
    int ed, em, ey, ee;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dc, dv, mv, yv, ee, m_dia, m_mes, m_anio;
    bit valid;
    logic [7:0] d, m, y;

    tbl[0] = '{8'h24, 8'h12, 8'h16, 24, 12, 16, 0};
`ifdef RTC_LECTOR_CHECK_EN
    tbl[1] = '{8'h24, 8'h13, 8'h16, 24, 12, 16, 1};
    tbl[2] = '{8'h3A, 8'h01, 8'h99, 24, 12, 16, 1};
    tbl[5] = '{8'h00, 8'h05, 8'h50, 1, 1, 0, 1};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 1, 1, 0, 1};
`else
    tbl[1] = '{8'h24, 8'h13, 8'h16, 24, 13, 16, 0};
    tbl[2] = '{8'h3A, 8'h01, 8'h99, 8, 1, 99, 0};
    tbl[5] = '{8'h00, 8'h05, 8'h50, 0, 5, 50, 0};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 5, 5, 37, 0};
`endif
    tbl[3] = '{8'h31, 8'h12, 8'h99, 31, 12, 99, 0};
    tbl[4] = '{8'h01, 8'h01, 8'h00, 1, 1, 0, 0};
    tbl[7] = '{8'h15, 8'h07, 8'h23, 15, 7, 23, 0};

    resetR = 1'b0; startR = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", int'({cs_n, wr_n, rd_n, a_d, ad_oe, busyR, doneR, errR}), 8'b1110_0000);
    chk("reset_ad_out", int'(ad_out), 0);
    chk("reset_date", int'({diaR, mesR, anioR}), int'({5'd1, 4'd1, 7'd0}));
    @(negedge clk); resetR = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_seq($sformatf("vec%0d", i), tbl[i].d, tbl[i].m, tbl[i].y,
              tbl[i].ed, tbl[i].em, tbl[i].ey, tbl[i].ee);
    end

    // Reset asserted while the address strobe is low.
    rtc_d = 8'h24; rtc_m = 8'h12; rtc_y = 8'h16;
    startR = 1'b1;
    @(posedge clk); #1;
    startR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_in_addr_wr", int'({cs_n, wr_n, ad_oe}), 3'b001);
    #2 resetR = 1'b0;
    #1;
    chk("midrst_release", int'({cs_n, wr_n, rd_n, ad_oe, busyR}), 5'b11100);
    chk("midrst_date", int'({diaR, mesR, anioR}), int'({5'd1, 4'd1, 7'd0}));
    repeat (2) @(posedge clk);
    @(negedge clk); resetR = 1'b1;
    dc = done_cnt;
    repeat (50) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, dc);
    chk("midrst_idle_bus", int'({cs_n, busyR}), 2'b10);

    // startR held high across two sequences.
    dc = done_cnt;
    startR = 1'b1;
    n = 0;
    while (doneR !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_first_latency", n, 38);
    @(posedge clk); #1;
    chk("held_gap_cs", int'(cs_n), 1);
    @(posedge clk); #1;
    chk("held_restart_cs", int'(cs_n), 0);
    startR = 1'b0;
    n = 2;
    while (doneR !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_second_spacing", n, 38);
    repeat (45) @(posedge clk);
    #1;
    chk("held_done_count", done_cnt - dc, 2);

    // Short-timing instance.
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fast_latency", n, 19);
    chk("fast_date", int'({dia2, mes2, anio2}), int'({5'd24, 4'd12, 7'd16}));
    chk("fast_err", int'(err2), 0);

    // Randomized dates against the reference model; reset left outputs at 1/1/0.
    m_dia = 1; m_mes = 1; m_anio = 0;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        d = to_bcd(int'($urandom_range(1, 31)));
        m = to_bcd(int'($urandom_range(1, 12)));
        y = to_bcd(int'($urandom_range(0, 99)));
      end else begin
        d = 8'($urandom_range(0, 255));
        m = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
      end
      dv = bcd_val(d); mv = bcd_val(m); yv = bcd_val(y);
      valid = nib_ok(d) && nib_ok(m) && nib_ok(y) && dv >= 1 && dv <= 31 && mv >= 1 && mv <= 12;
`ifdef RTC_LECTOR_CHECK_EN
      ee = valid ? 0 : 1;
      if (valid) begin
        m_dia = dv; m_mes = mv; m_anio = yv;
      end
`else
      ee = 0;
      m_dia = dv % 32; m_mes = mv % 16; m_anio = yv;
`endif
      run_seq($sformatf("rnd%0d", k), d, m, y, m_dia, m_mes, m_anio, ee);
    end

    chk("no_drive_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_lector_fecha.md
# rtc_lector_fecha

Bus-side reader that fetches the day, month and year registers from the external RTC over its multiplexed address/data bus and converts them from BCD to binary. It sits between the RTC bus pins and the date-display and edit logic. It is the read-direction counterpart of the month/day/year edit counters: those produce values to be written, and this block brings the chip's current values back. One request triggers three back-to-back register reads and ends in a single-cycle `doneR` pulse.

## Interface
Parameters:
- `T_PULSE`, 4: cycles each strobe (`wr_n` or `rd_n`) is held low; legal range 2..15.
- `T_GAP`, 2: idle cycles after each register access, with `cs_n` high.
- `ADDR_DIA`, 8'h24: RTC day register address.
- `ADDR_MES`, 8'h25: RTC month register address.
- `ADDR_ANIO`, 8'h26: RTC year register address.

Ports:
- `clkR`, in, 1: clock; all logic on the rising edge.
- `resetR`, in, 1: asynchronous, active-low reset.
- `startR`, in, 1: read request; sampled only in IDLE.
- `ad_in`, in, 8: AD bus value as driven by the RTC.
- `ad_out`, out, 8: AD value driven by this block.
- `ad_oe`, out, 1: 1 means this block drives AD.
- `cs_n`, out, 1: RTC chip select, active-low.
- `wr_n`, out, 1: write strobe, active-low.
- `rd_n`, out, 1: read strobe, active-low.
- `a_d`, out, 1: 0 selects the address phase, 1 selects the data phase.
- `diaR`, out, 5: day in binary, 1..31.
- `mesR`, out, 4: month in binary, 1..12.
- `anioR`, out, 7: year in binary, 0..99.
- `busyR`, out, 1: high from the start-accept edge until `doneR`.
- `doneR`, out, 1: one-cycle pulse when the sequence ends.
- `errR`, out, 1: one-cycle pulse coincident with `doneR` when a read value is invalid.

## Operation
- FSM states: IDLE, ADDR_SETUP, ADDR_WR, DATA_SETUP, DATA_RD, GAP, DONE.
- Register index `idx` runs 0, 1, 2, selecting day, month, year.
- IDLE:
  - Bus is released: `cs_n`=`wr_n`=`rd_n`=1, `a_d`=0, `ad_oe`=0.
  - When `startR`=1, `idx` is cleared and the FSM goes to ADDR_SETUP.
- ADDR_SETUP, 1 cycle: `cs_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=address[idx].
- ADDR_WR, `T_PULSE` cycles: ADDR_SETUP outputs are held and `wr_n`=0.
- DATA_SETUP, 1 cycle: `wr_n`=1, `ad_oe`=0, `a_d`=1, `cs_n`=0.
- DATA_RD, `T_PULSE` cycles:
  - `rd_n`=0.
  - `ad_in` is captured into a raw byte register on the last DATA_RD edge.
- GAP, `T_GAP` cycles:
  - Bus is released.
  - If `idx`<2, `idx` is incremented and the FSM goes to ADDR_SETUP; otherwise it goes to DONE.
- DONE, 1 cycle: `doneR`=1, then the FSM returns to IDLE.
- BCD conversion: value = high nibble × 10 + low nibble, computed at 7-bit width and truncated to the output width.
- `diaR`, `mesR` and `anioR` update together in the DONE cycle, from the three captured bytes.
- `ad_oe` and `rd_n` are never both active. A wait cycle (DATA_SETUP) always separates driver hand-over.
- `startR` while busy is ignored and not queued. `startR` held high re-triggers on the cycle after DONE.
- Reset mid-sequence: the bus is released immediately (asynchronous), the FSM goes to IDLE and the partial read is discarded.

## Timing
- All outputs are registered.
- Reset values:
  - `cs_n`=`wr_n`=`rd_n`=1
  - `a_d`=0, `ad_oe`=0, `ad_out`=0
  - `diaR`=1, `mesR`=1, `anioR`=0
  - `busyR`=`doneR`=`errR`=0
- Per-register access: `2*T_PULSE + T_GAP + 2` cycles.
- `doneR` is asserted `3*(2*T_PULSE+T_GAP+2) + 1` cycles after the edge that samples `startR`. With defaults this is 37 cycles.
- `busyR` rises on the edge after `startR` is sampled and falls on the edge after `doneR`.

## Configuration
- Macro: `RTC_LECTOR_CHECK_EN`.
- Defined:
  - A value is invalid if any nibble exceeds 9, if day is outside 1..31, or if month is outside 1..12.
  - If any value is invalid, `errR` pulses with `doneR` and all three date outputs keep their previous values.
- Undefined:
  - No checking is done and `errR` is tied to 0.
  - Converted values are always loaded, truncated to the output width.

## Test plan
- Reset held mid-ADDR_WR -> `cs_n`=1 and `ad_oe`=0 within the same cycle; outputs read 1/1/0; `busyR`=0.
- `startR` pulse with RTC model returning 8'h24, 8'h12, 8'h16 (defaults) -> bus trace shows address bytes 24, 25, 26 in order; `doneR` at cycle 37; outputs `diaR`=24, `mesR`=12, `anioR`=16; `errR`=0.
- Month byte 8'h13 with `RTC_LECTOR_CHECK_EN` -> `errR`=`doneR`=1 and outputs unchanged. Same byte without the macro -> `mesR`=13 (4'hD), `errR`=0.
- Day byte 8'h3A with the macro -> `errR` pulse; without the macro -> `diaR` = (3×10+10) mod 32 = 8.
- `startR` held high across two sequences -> second ADDR_SETUP begins the cycle after the first DONE; no extra `doneR` pulses.
- `T_PULSE`=2, `T_GAP`=0 -> `doneR` at cycle 19; at every edge, `ad_oe` and `!rd_n` are never both 1.
